score_keeper: RTL
=================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter TICKS_PER_POINT, default 60, meaning tick pulses per awarded point (legal range 1..1023).
REQ-002 SHALL have parameter BONUS_POINTS, default 10, meaning points added per bonus pulse (legal range 0..9999).
REQ-003 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port game_start  input  1  one-cycle pulse that starts a new game.
REQ-006 SHALL have port game_over  input  1  one-cycle pulse that ends the current game.
REQ-007 SHALL have port tick  input  1  one-cycle time-base pulse, e.g. once per frame.
REQ-008 SHALL have port bonus  input  1  one-cycle pulse for one meteor dodged.
REQ-009 SHALL have port score  output  16  binary current score, 0..9999, feeding the 4-digit display.
REQ-010 SHALL have port high_score  output  16  binary best score since reset.
REQ-011 SHALL have port new_high  output  1  current/last game set a new high score.
REQ-012 SHALL have port running  output  1  FSM is in RUNNING.

Function
REQ-013 SHALL implement FSM states IDLE, RUNNING, OVER.
REQ-014 SHALL transition IDLE->RUNNING and OVER->RUNNING on game_start; clear score, tick divider and new_high in that same edge.
REQ-015 SHALL transition RUNNING->OVER on game_over; ignore game_over in IDLE and OVER.
REQ-016 SHALL ignore game_start in RUNNING; no restart mid-game.
REQ-017 SHALL count tick only in RUNNING; each TICKS_PER_POINT-th counted tick awards 1 point and wraps the divider to 0.
REQ-018 SHALL award BONUS_POINTS per bonus pulse in RUNNING only.
REQ-019 SHALL sum tick point and bonus in the same cycle, giving 1+BONUS_POINTS.
REQ-020 SHALL saturate score at 9999; never wrap, extra points are discarded.
REQ-021 SHALL perform the addition in at least 17 bits before the saturation compare.
REQ-022 SHALL give precedence to game_over over tick/bonus in the same cycle; no points are awarded that cycle.
REQ-023 SHALL make score visible one clock after the qualifying event edge; no further latency.
REQ-024 SHALL hold score frozen in OVER and IDLE.
REQ-025 SHALL on RUNNING->OVER, if score > high_score, load high_score with score next cycle and set new_high; equal scores leave new_high at 0.
REQ-026 SHALL hold new_high until the next game_start or reset.
REQ-027 SHALL drive running combinationally from the state register; no glitch-free requirement beyond that.

Reset
REQ-028 SHALL on reset force state IDLE, score 0, high_score 0, new_high 0, running 0, divider 0.
REQ-029 SHALL give reset priority over every input, including mid-game and same-cycle game_start.

Configuration
REQ-030 SHALL when macro SCORE_KEEPER_HIGH_SCORE_EN is defined implement REQ-025/REQ-026 high-score tracking.
REQ-031 SHALL when SCORE_KEEPER_HIGH_SCORE_EN is undefined tie high_score to 0 and new_high to 0, with no high-score register synthesized; all other behaviour unchanged.

Structure
REQ-032 SHALL place the state enum typedef and constant MAX_SCORE = 9999 in shared package score_pkg.
REQ-033 SHALL implement the tick divider as sub-module tick_divider: inputs clk, reset, clear, enable, tick; output point pulse; parameter TICKS_PER_POINT.

Verification (TICKS_PER_POINT=4, BONUS_POINTS=10)
REQ-034 SHALL cover: reset, game_start, 8 ticks -> score 2, running 1; score changes exactly one cycle after the 4th and 8th ticks.
REQ-035 SHALL cover: in RUNNING, 3 ticks then tick+bonus in the same cycle -> score 11.
REQ-036 SHALL cover: score preloaded via 999 bonus pulses to 9990, then 2 bonus pulses -> score 9999 and stays 9999.
REQ-037 SHALL cover: game_over coincident with 4th tick -> score unchanged, state OVER, later ticks/bonus ignored.
REQ-038 SHALL cover: game 1 ends at 25 -> high_score 25, new_high 1; game_start -> score 0, new_high 0; game 2 ends at 25 -> new_high 0, high_score 25.
REQ-039 SHALL cover: reset asserted mid-game at score 40 -> all outputs 0 next cycle, game_start in the reset cycle ignored; run with and without SCORE_KEEPER_HIGH_SCORE_EN.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: game FSM states and score limits.
package score_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      OVER    = 2'd2
   } state_e;

   localparam int unsigned MAX_SCORE = 9999;
   localparam int unsigned SCORE_W   = 16;
   // One bit of headroom so the raw sum never wraps before saturation.
   localparam int unsigned SUM_W     = 17;
   localparam int unsigned DIV_W     = 10;

endpackage

// File: rtl/tick_divider.sv
// Divides the tick time base down to one-cycle point pulses; every TICKS_PER_POINT-th
// enabled tick produces a same-cycle point and wraps the counter.
module tick_divider
   import score_pkg::*;
#(
   parameter int unsigned TICKS_PER_POINT = 60
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   input  logic tick,
   output logic point
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             at_last;

   assign at_last = (cnt_q == DIV_W'(TICKS_PER_POINT - 1));

   // Point is combinational so the score register can absorb it on the same edge.
   always_comb begin
      cnt_d = cnt_q;
      point = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && tick) begin
         if (at_last) begin
            cnt_d = '0;
            point = 1'b1;
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/score_keeper.sv
// Game score keeper: IDLE/RUNNING/OVER FSM, saturating score, optional high-score
// tracking enabled by defining SCORE_KEEPER_HIGH_SCORE_EN.
module score_keeper
   import score_pkg::*;
#(
   parameter int unsigned TICKS_PER_POINT = 60,
   parameter int unsigned BONUS_POINTS    = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               game_start,
   input  logic               game_over,
   input  logic               tick,
   input  logic               bonus,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score,
   output logic               new_high,
   output logic               running
);

   state_e             state_q, state_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SUM_W-1:0]   sum;
   logic               start_ok;
   logic               award_en;
   logic               point;

   assign start_ok = game_start && (state_q != RUNNING);
   // game_over wins over tick/bonus: nothing is counted or awarded that cycle.
   assign award_en = (state_q == RUNNING) && !game_over;

   tick_divider #(
      .TICKS_PER_POINT(TICKS_PER_POINT)
   ) u_tick_divider (
      .clk    (clk),
      .reset  (reset),
      .clear  (start_ok),
      .enable (award_en),
      .tick   (tick),
      .point  (point)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (game_start) state_d = RUNNING;
         RUNNING: if (game_over)  state_d = OVER;
         OVER:    if (game_start) state_d = RUNNING;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      running = (state_q == RUNNING);
   end

   always_comb begin
      sum     = SUM_W'(score_q) + SUM_W'(point) + (bonus ? SUM_W'(BONUS_POINTS) : SUM_W'(0));
      score_d = score_q;
      if (start_ok) begin
         score_d = '0;
      end else if (award_en) begin
         score_d = (sum > SUM_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) score_q <= '0;
      else       score_q <= score_d;
   end

   assign score = score_q;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
   logic [SCORE_W-1:0] high_q, high_d;
   logic               new_high_q, new_high_d;
   logic               end_ok;

   assign end_ok = game_over && (state_q == RUNNING);

   // A tie with the stored best does not count as a new high.
   always_comb begin
      high_d     = high_q;
      new_high_d = new_high_q;
      if (start_ok) begin
         new_high_d = 1'b0;
      end else if (end_ok && (score_q > high_q)) begin
         high_d     = score_q;
         new_high_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         high_q     <= '0;
         new_high_q <= 1'b0;
      end else begin
         high_q     <= high_d;
         new_high_q <= new_high_d;
      end
   end

   assign high_score = high_q;
   assign new_high   = new_high_q;
`else
   assign high_score = '0;
   assign new_high   = 1'b0;
`endif

endmodule
